// File: rtl/sar_sequencer.sv
// sar_sequencer: control sequencer for an 8-bit successive-approximation ADC.
// Samples for SAMPLE_CYC cycles, then resolves one bit per comparator decision
// (MSB first), publishes the result with a one-cycle VALID pulse and aborts
// with a one-cycle ERR pulse if the comparator goes silent for TIMEOUT_CYC
// cycles.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   conversion request, level-sampled
//   rdy    in   comparator done strobe (asynchronous)
//   comp   in   comparator decision (asynchronous, stable while rdy high)
//   cks    out  0 = sample, 1 = convert
//   dac    out  trial code for the capacitive DAC
//   step   out  thermometer count of completed decisions
//   dout   out  last valid conversion result
//   valid  out  one-cycle pulse when dout updates
//   busy   out  high in SAMPLE, CONVERT and DONE
//   err    out  one-cycle pulse on watchdog abort
module sar_sequencer #(
  parameter int unsigned SAMPLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rdy,
  input  logic       comp,
  output logic       cks,
  output logic [7:0] dac,
  output logic [7:0] step,
  output logic [7:0] dout,
  output logic       valid,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYC);
  localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state;
  logic               rdy_s1, rdy_s2, rdy_d;
  logic               comp_s1, comp_s2;
  logic [CNT_W-1:0]   smp_cnt;
  logic [CNT_W-1:0]   wdog;
  logic [IDX_W-1:0]   bit_idx;
  logic               dec_evt;
  logic [7:0]         dac_dec;

  // Two-flop synchronizers; rdy_d holds the previous synchronized rdy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_s1  <= 1'b0;
      rdy_s2  <= 1'b0;
      rdy_d   <= 1'b0;
      comp_s1 <= 1'b0;
      comp_s2 <= 1'b0;
    end else begin
      rdy_s1  <= rdy;
      rdy_s2  <= rdy_s1;
      rdy_d   <= rdy_s2;
      comp_s1 <= comp;
      comp_s2 <= comp_s1;
    end
  end

  assign dec_evt = rdy_s2 & ~rdy_d;

  // Trial code after applying the current decision: resolve bit_idx, arm the next lower bit
  always_comb begin
    dac_dec          = dac;
    dac_dec[bit_idx] = comp_s2;
    if (bit_idx != IDX_W'(0)) begin
      dac_dec[bit_idx - IDX_W'(1)] = 1'b1;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      smp_cnt <= '0;
      wdog    <= '0;
      bit_idx <= '0;
      cks     <= 1'b0;
      dac     <= 8'h00;
      step    <= 8'h00;
      dout    <= 8'h00;
      valid   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          cks <= 1'b0;
          if (start) begin
            state   <= SAMPLE;
            smp_cnt <= SAMPLE_LOAD;
            dac     <= 8'h80;
            step    <= 8'h00;
            busy    <= 1'b1;
          end
        end

        SAMPLE: begin
          // Leaving on the last of SAMPLE_CYC sample cycles
          if (smp_cnt <= CNT_W'(1)) begin
            state   <= CONVERT;
            cks     <= 1'b1;
            wdog    <= '0;
            bit_idx <= IDX_W'(7);
          end else begin
            smp_cnt <= smp_cnt - CNT_W'(1);
          end
        end

        CONVERT: begin
          // A decision wins over a coincident watchdog expiry
          if (dec_evt) begin
            dac  <= dac_dec;
            step <= {step[6:0], 1'b1};
            wdog <= '0;
            if (bit_idx == IDX_W'(0)) begin
              state <= DONE;
              cks   <= 1'b0;
              dout  <= dac_dec;
              valid <= 1'b1;
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
            end
          end else if (wdog >= WDOG_LAST) begin
            state <= IDLE;
            cks   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            wdog  <= '0;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        DONE: begin
          cks <= 1'b0;
          if (start) begin
            state   <= SAMPLE;
            smp_cnt <= SAMPLE_LOAD;
            dac     <= 8'h80;
            step    <= 8'h00;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cks   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sar_sequencer.md
SAR_SEQUENCER -- requirements
Module: sar_sequencer

Interface
REQ-001 Parameter SAMPLE_CYC, default 4, sets the number of CLK cycles CKS is held low for sampling (legal range 1-255).
REQ-002 Parameter TIMEOUT_CYC, default 64, sets the number of CLK cycles allowed between comparator ready edges before abort (legal range 2-255).
REQ-003 CLK  in  1  single system clock; all state updates occur on rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 START  in  1  conversion request, level-sampled on CLK.
REQ-006 RDY  in  1  comparator-done strobe, asynchronous to CLK, one rising edge per decision.
REQ-007 COMP  in  1  comparator decision, asynchronous, stable while RDY is high.
REQ-008 CKS  out  1  sample/convert control: 0 = sample (clears the downstream cycle flags), 1 = convert.
REQ-009 DAC  out  8  current trial code driven to the capacitive DAC.
REQ-010 STEP  out  8  thermometer count of completed decisions (bit i set after decision i+1).
REQ-011 DOUT  out  8  last valid conversion result.
REQ-012 VALID  out  1  one-cycle pulse when DOUT updates.
REQ-013 BUSY  out  1  high in SAMPLE, CONVERT and DONE.
REQ-014 ERR  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 RDY and COMP SHALL each pass through a 2-flop synchronizer; a decision event is the cycle where the synchronized RDY is 1 and its previous value was 0; COMP is taken from the same synchronizer stage as RDY in that cycle.
REQ-016 The FSM SHALL have states IDLE, SAMPLE, CONVERT and DONE.
REQ-017 IDLE: CKS=0, BUSY=0; START=1 moves to SAMPLE on the next edge, loads the sample counter to SAMPLE_CYC and loads DAC=8'h80 and STEP=0.
REQ-018 SAMPLE: CKS=0 for exactly SAMPLE_CYC cycles; on counter expiry the FSM moves to CONVERT, sets CKS=1 and clears the watchdog.
REQ-019 CONVERT: decision k (k=7 down to 0) SHALL clear DAC[k] if COMP=0 or keep it if COMP=1, then set DAC[k-1]=1 when k>0, and shift a 1 into STEP LSB.
REQ-020 After the 8th decision (k=0) the FSM SHALL move to DONE in the same edge that applies the final decision.
REQ-021 DONE (one cycle): DOUT<=DAC, VALID=1, CKS=0; next state is SAMPLE if START=1 (back-to-back operation), otherwise IDLE.
REQ-022 The watchdog SHALL count CLK cycles in CONVERT, reset on every decision event, and on reaching TIMEOUT_CYC force IDLE, CKS=0, ERR=1 for one cycle, with DOUT unchanged and no VALID.
REQ-023 Decision events in IDLE, SAMPLE or DONE SHALL be ignored with no state change.
REQ-024 START while BUSY=1 SHALL be ignored, except in DONE as per REQ-021.
REQ-025 A decision event coinciding with watchdog expiry SHALL be applied as a decision; the timeout does not fire in that cycle.
REQ-026 Latency from START sampled high to first CKS=1 SHALL be SAMPLE_CYC+1 cycles; from the 8th decision event to VALID, 1 cycle.
REQ-027 All outputs SHALL be registered; VALID and ERR are never high in the same cycle.

Reset
REQ-028 RST=1 at any clock edge SHALL force IDLE, CKS=0, DAC=8'h00, STEP=0, DOUT=8'h00, VALID=0, BUSY=0, ERR=0, clear all counters and synchronizer flops; this takes priority over every other input, including mid-conversion.
REQ-029 After RST is released, the first START SHALL begin a full conversion with no residue from the aborted one.

Verification
REQ-030 START pulse; comparator model answers COMP=1,0,1,1,0,0,1,0 over 8 RDY pulses -> DAC walks 80,C0,A0,B0,B8,B4,B2,B3; DOUT=8'hB2; VALID is a single cycle; CKS drops to 0 in DONE.
REQ-031 START held high continuously with all COMP=1 -> repeated conversions, DOUT=8'hFF each time, SAMPLE re-entered directly from DONE, CKS low for exactly SAMPLE_CYC+1 cycles between conversions.
REQ-032 Only 3 RDY pulses, then silence -> ERR pulse TIMEOUT_CYC cycles after the 3rd decision event, state IDLE, DOUT keeps its previous value, VALID stays 0.
REQ-033 RST asserted after the 5th decision -> next edge: all outputs at reset values; a following START with all COMP=0 gives DOUT=8'h00.
REQ-034 RDY pulses applied in IDLE and SAMPLE, and START pulses applied during CONVERT -> no change to DAC, STEP or state.
REQ-035 RDY pulse arriving on the final watchdog cycle -> the decision is applied and ERR stays 0.
